libv_deque_hs: RTL and testbench

// - Parametrised double-ended queue: push/pop at front or back, one command per cycle.
// - Adds to the basic deque: illegal-op drop, registered pop response, occupancy count, flush.
// - Shared buffering primitive for libv consumers that need both LIFO and FIFO access.
//

---
 rtl/libv_deque_hs.sv | 176 +++++++++++++++++
 tb/tb_libv_deque_hs.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/libv_deque_hs.sv
// libv_deque_hs: parametrised double-ended queue with push/pop at either end,
// one command per cycle, illegal-op drop, registered pop response, occupancy
// count and synchronous flush.
//
// Optional feature macro: LIBV_DEQUE_HS_ERR_EN
//   defined   -> sticky err_ovf_r / err_udf_r flops, cleared by flush or reset
//   undefined -> err_ovf_r / err_udf_r tied to 0
//
// Ports:
//   clk           clock, all state on posedge
//   rst           asynchronous reset, active-low
//   flush         synchronous clear of contents (wins over same-cycle cmd)
//   cmd_vld       command valid
//   cmd_op        2'd0 PushFront, 2'd1 PopFront, 2'd2 PushBack, 2'd3 PopBack
//   cmd_push_data data for push ops
//   cmd_ack       comb: cmd_vld and op legal in current state (informational)
//   rsp_vld       registered: pop data valid, one cycle after accepted pop
//   rsp_data      registered pop data, holds last value
//   count_r       occupancy 0..N
//   empty_r       count_r == 0
//   full_r        count_r == N
//   err_ovf_r     sticky: push attempted while full
//   err_udf_r     sticky: pop attempted while empty
module libv_deque_hs #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  cmd_vld,
  input  logic [1:0]            cmd_op,
  input  logic [W-1:0]          cmd_push_data,
  output logic                  cmd_ack,
  output logic                  rsp_vld,
  output logic [W-1:0]          rsp_data,
  output logic [$clog2(N):0]    count_r,
  output logic                  empty_r,
  output logic                  full_r,
  output logic                  err_ovf_r,
  output logic                  err_udf_r
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned PW = AW + 1;

  // Op encoding: bit 0 selects pop, bit 1 selects the back end.
  localparam logic [1:0] OP_PUSH_FRONT = 2'd0;
  localparam logic [1:0] OP_POP_FRONT  = 2'd1;
  localparam logic [1:0] OP_PUSH_BACK  = 2'd2;
  localparam logic [1:0] OP_POP_BACK   = 2'd3;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic [W-1:0]  rsp_data_q, rsp_data_d;
  logic [W-1:0]  mem_q [N];

  logic          is_pop;
  logic          legal;
  logic          accept;
  logic [PW-1:0] head_m1;
  logic [PW-1:0] tail_m1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [AW-1:0] rd_addr;

  // Occupancy and flags follow directly from the registered pointers.
  assign count_r = tail_q - head_q;
  assign empty_r = (count_r == PW'(0));
  assign full_r  = (count_r == PW'(N));
  assign rsp_vld  = rsp_vld_q;
  assign rsp_data = rsp_data_q;

  assign is_pop  = cmd_op[0];
  assign legal   = !(!is_pop && full_r) && !(is_pop && empty_r);
  assign cmd_ack = cmd_vld && legal;
  assign accept  = cmd_ack && !flush;
  assign head_m1 = head_q - PW'(1);
  assign tail_m1 = tail_q - PW'(1);

  // Next-state for pointers, memory write port and pop response.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    rsp_vld_d  = 1'b0;
    rsp_data_d = rsp_data_q;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = cmd_push_data;
    rd_addr    = cmd_op[1] ? tail_m1[AW-1:0] : head_q[AW-1:0];
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else if (accept) begin
      case (cmd_op)
        OP_PUSH_FRONT: begin
          head_d  = head_m1;
          wr_en   = 1'b1;
          wr_addr = head_m1[AW-1:0];
        end
        OP_POP_FRONT: begin
          head_d     = head_q + PW'(1);
          rsp_vld_d  = 1'b1;
          rsp_data_d = mem_q[rd_addr];
        end
        OP_PUSH_BACK: begin
          tail_d  = tail_q + PW'(1);
          wr_en   = 1'b1;
          wr_addr = tail_q[AW-1:0];
        end
        OP_POP_BACK: begin
          tail_d     = tail_m1;
          rsp_vld_d  = 1'b1;
          rsp_data_d = mem_q[rd_addr];
        end
        default: ;
      endcase
    end
  end

  // Control and response state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Storage: no reset, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

`ifdef LIBV_DEQUE_HS_ERR_EN
  logic err_ovf_q, err_ovf_d;
  logic err_udf_q, err_udf_d;

  // Sticky error flags; flush clears them even if an illegal op arrives with it.
  always_comb begin
    err_ovf_d = err_ovf_q || (cmd_vld && !is_pop && full_r);
    err_udf_d = err_udf_q || (cmd_vld && is_pop && empty_r);
    if (flush) begin
      err_ovf_d = 1'b0;
      err_udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_ovf_r = err_ovf_q;
  assign err_udf_r = err_udf_q;
`else
  assign err_ovf_r = 1'b0;
  assign err_udf_r = 1'b0;
`endif

endmodule

// File: tb/tb_libv_deque_hs.sv
// Directed bench for libv_deque_hs at W=8, N=4.
module tb_libv_deque_hs;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  localparam logic [1:0] PUSH_FRONT = 2'd0;
  localparam logic [1:0] POP_FRONT  = 2'd1;
  localparam logic [1:0] PUSH_BACK  = 2'd2;
  localparam logic [1:0] POP_BACK   = 2'd3;

`ifdef LIBV_DEQUE_HS_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         cmd_vld;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_push_data;
  logic         cmd_ack;
  logic         rsp_vld;
  logic [W-1:0] rsp_data;
  logic [2:0]   count_r;
  logic         empty_r;
  logic         full_r;
  logic         err_ovf_r;
  logic         err_udf_r;

  int checks = 0;
  int errors = 0;

  libv_deque_hs #(.W(W), .N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .cmd_vld      (cmd_vld),
    .cmd_op       (cmd_op),
    .cmd_push_data(cmd_push_data),
    .cmd_ack      (cmd_ack),
    .rsp_vld      (rsp_vld),
    .rsp_data     (rsp_data),
    .count_r      (count_r),
    .empty_r      (empty_r),
    .full_r       (full_r),
    .err_ovf_r    (err_ovf_r),
    .err_udf_r    (err_udf_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check cmd_ack ahead of the edge, return at edge+1.
  task automatic cmd(input logic v, input logic [1:0] op, input logic [7:0] d,
                     input logic f, input logic exp_ack);
    cmd_vld       = v;
    cmd_op        = op;
    cmd_push_data = d;
    flush         = f;
    #1;
    if (v) chk("cmd_ack", 32'(cmd_ack), 32'(exp_ack));
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic chk_pop(input string tag, input logic [7:0] exp);
    chk({tag, "_vld"}, 32'(rsp_vld), 32'd1);
    chk({tag, "_data"}, 32'(rsp_data), 32'(exp));
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; cmd_vld = 1'b0; cmd_op = '0; cmd_push_data = '0;
    #12;
    chk("rst_empty", 32'(empty_r), 32'd1);
    chk("rst_full", 32'(full_r), 32'd0);
    chk("rst_count", 32'(count_r), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_err_ovf", 32'(err_ovf_r), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // FIFO through back/front
    cmd(1, PUSH_BACK, 8'h11, 0, 1); chk("fifo_cnt1", 32'(count_r), 32'd1);
    chk("fifo_empty1", 32'(empty_r), 32'd0);
    cmd(1, PUSH_BACK, 8'h22, 0, 1); chk("fifo_cnt2", 32'(count_r), 32'd2);
    cmd(1, PUSH_BACK, 8'h33, 0, 1); chk("fifo_cnt3", 32'(count_r), 32'd3);
    chk("fifo_notfull", 32'(full_r), 32'd0);
    cmd(1, PUSH_BACK, 8'h44, 0, 1); chk("fifo_cnt4", 32'(count_r), 32'd4);
    chk("fifo_full", 32'(full_r), 32'd1);
    cmd(1, POP_FRONT, 8'h00, 0, 1); chk_pop("fifo_pop1", 8'h11);
    cmd(1, POP_FRONT, 8'h00, 0, 1); chk_pop("fifo_pop2", 8'h22);
    cmd(1, POP_FRONT, 8'h00, 0, 1); chk_pop("fifo_pop3", 8'h33);
    cmd(1, POP_FRONT, 8'h00, 0, 1); chk_pop("fifo_pop4", 8'h44);
    chk("fifo_empty", 32'(empty_r), 32'd1);
    cmd(0, PUSH_BACK, 8'h00, 0, 0);
    chk("idle_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("idle_rsp_hold", 32'(rsp_data), 32'h44);

    // LIFO at front
    cmd(1, PUSH_FRONT, 8'hA1, 0, 1);
    chk("lifo_rsp_vld", 32'(rsp_vld), 32'd0);
    cmd(1, PUSH_FRONT, 8'hA2, 0, 1);
    cmd(1, POP_FRONT, 8'h00, 0, 1); chk_pop("lifo_pop1", 8'hA2);
    cmd(1, POP_FRONT, 8'h00, 0, 1); chk_pop("lifo_pop2", 8'hA1);

    // Overflow drop
    cmd(1, PUSH_BACK, 8'h01, 0, 1);
    cmd(1, PUSH_BACK, 8'h02, 0, 1);
    cmd(1, PUSH_BACK, 8'h03, 0, 1);
    cmd(1, PUSH_BACK, 8'h04, 0, 1);
    cmd(1, PUSH_BACK, 8'h55, 0, 0);
    chk("ovf_count", 32'(count_r), 32'd4);
    chk("ovf_full", 32'(full_r), 32'd1);
    chk("ovf_err", 32'(err_ovf_r), 32'(EXP_ERR));
    chk("ovf_no_udf", 32'(err_udf_r), 32'd0);
    cmd(1, POP_BACK, 8'h00, 0, 1); chk_pop("ovf_popb", 8'h04);
    chk("ovf_err_sticky", 32'(err_ovf_r), 32'(EXP_ERR));
    cmd(1, POP_FRONT, 8'h00, 0, 1); chk_pop("ovf_popf", 8'h01);
    chk("ovf_cnt2", 32'(count_r), 32'd2);
    cmd(0, PUSH_BACK, 8'h00, 1, 0);
    chk("flush1_cnt", 32'(count_r), 32'd0);
    chk("flush1_empty", 32'(empty_r), 32'd1);
    chk("flush1_err", 32'(err_ovf_r), 32'd0);

    // Underflow drop
    cmd(1, POP_BACK, 8'h00, 0, 0);
    chk("udf_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("udf_rsp_hold", 32'(rsp_data), 32'h01);
    chk("udf_count", 32'(count_r), 32'd0);
    chk("udf_err", 32'(err_udf_r), 32'(EXP_ERR));
    cmd(0, PUSH_BACK, 8'h00, 1, 0);
    chk("flush2_err", 32'(err_udf_r), 32'd0);

    // Flush beats a same-cycle push
    cmd(1, PUSH_BACK, 8'h10, 0, 1);
    cmd(1, PUSH_BACK, 8'h20, 0, 1);
    cmd(1, PUSH_BACK, 8'h30, 0, 1);
    chk("pre_flush_cnt", 32'(count_r), 32'd3);
    cmd(1, PUSH_BACK, 8'h77, 1, 1);
    chk("flush3_cnt", 32'(count_r), 32'd0);
    chk("flush3_empty", 32'(empty_r), 32'd1);
    cmd(1, POP_FRONT, 8'h00, 0, 0);
    chk("flush3_dropped", 32'(rsp_vld), 32'd0);

    // Pointer wrap below zero at the front
    cmd(1, PUSH_FRONT, 8'h88, 0, 1);
    cmd(1, PUSH_BACK, 8'h99, 0, 1);
    chk("wrap_cnt", 32'(count_r), 32'd2);
    cmd(1, POP_FRONT, 8'h00, 0, 1); chk_pop("wrap_popf", 8'h88);
    cmd(1, POP_BACK, 8'h00, 0, 1); chk_pop("wrap_popb", 8'h99);
    chk("wrap_empty", 32'(empty_r), 32'd1);

    // Async reset discards in-flight response
    cmd(1, PUSH_BACK, 8'h5A, 0, 1);
    cmd(1, PUSH_BACK, 8'h5B, 0, 1);
    cmd(1, POP_FRONT, 8'h00, 0, 1); chk_pop("mid_pop", 8'h5A);
    rst = 1'b0;
    #2;
    chk("mid_rst_vld", 32'(rsp_vld), 32'd0);
    chk("mid_rst_data", 32'(rsp_data), 32'd0);
    chk("mid_rst_cnt", 32'(count_r), 32'd0);
    chk("mid_rst_empty", 32'(empty_r), 32'd1);
    chk("mid_rst_full", 32'(full_r), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cmd(1, PUSH_BACK, 8'hC3, 0, 1);
    cmd(1, POP_BACK, 8'h00, 0, 1); chk_pop("post_rst", 8'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
